dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two masters: M0 = pipeline MEM stage (loads/stores), M1 = secondary master (debug/DMA loader).
- Round-robin arbitration with bounded bursts, at most one memory access per cycle, same-cycle grant.
- Read data and exception are registered and returned one cycle later with a valid strobe.
- Sits between the MEM-stage/M1 request buses and the data memory (widthCtrl/extendCtrl/address/writeData/readData/exception interface).

Parameters:
- BURST_MAX, 4: max consecutive grants to one master while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mN_req  in  1  access request, N = 0,1. Every mN_* port exists for both masters.
- mN_we  in  1  store when 1, load when 0
- mN_width  in  2  memWidth4/memWidth2/memWidth1 code
- mN_ext  in  1  sign-extend sub-word load
- mN_addr  in  32  byte address
- mN_wdata  in  32  store data
- mN_pc  in  32  debug PC forwarded to memory
- mN_gnt  out  1  combinational grant, this cycle
- mN_rvalid  out  1  response valid, one cycle after grant
- mN_rdata  out  32  registered load data
- mN_exc  out  1  registered memory exception for the granted access
- mem_we  out  1  memory write enable
- mem_width  out  2  to memory widthCtrl
- mem_ext  out  1  to memory extendCtrl
- mem_addr  out  32  to memory address
- mem_wdata  out  32  to memory writeDataIn
- mem_pc  out  32  to memory debugPC
- mem_rdata  in  32  memory readData (combinational)
- mem_exc  in  1  memory exception (combinational)

Behaviour:
- Reset is synchronous, active-high, clock clk.
- Reset values: owner = NONE, last = M1 (so M0 wins first tie), burst_cnt = 0, all gnt/rvalid/exc = 0, rdata = 0.
- While reset is high, mem_we = 0 and gnt = 0 regardless of requests.
- State: owner {NONE, M0, M1}, last (last granted master), burst_cnt (4 bits).
- Grant decision, combinational, each cycle:
  - owner = o, req_o = 1, and (req_other = 0 or burst_cnt < BURST_MAX): grant o.
  - Otherwise, if req_other = 1: grant other.
  - Otherwise, if both requesting from NONE: grant the master != last.
  - Otherwise, grant the single requester, or none.
- At the posedge after a grant: owner <= granted master; last <= granted master.
  - burst_cnt <= min(burst_cnt + 1, BURST_MAX) if same owner, else 1.
- No grant in a cycle: owner <= NONE, burst_cnt <= 0; last is unchanged.
- Granted master's fields are muxed to mem_*; mem_we = gnt & we.
- When idle, all mem_* outputs are driven 0; mem_we = 0 always when idle.
- Requester holds req and all fields stable until it sees gnt. The access completes at the posedge of the grant cycle.
- Response, at that same edge:
  - mN_rdata <= mem_rdata; mN_exc <= mem_exc; mN_rvalid <= 1 for exactly one cycle.
  - Stores also produce rvalid, carrying the exc flag.
- The non-granted master's rdata/exc hold their previous values; its rvalid = 0.
- Back-to-back grants to the same master give consecutive rvalid pulses.
- Exceptions do not suppress the memory write. The requester squashes on mN_exc.
- BURST_MAX = 1 degenerates to strict alternation under contention.
- Reset asserted mid-burst or with a pending response: state and rvalid cleared at that edge, no write issued.

Optional Feature:
- Macro: DM_ARB_PERFCNT_EN.
- Defined: adds outputs m0_stall_cnt[31:0] and m1_stall_cnt[31:0].
  - Each counts cycles with mN_req & ~mN_gnt, saturating at 32'hFFFFFFFF, cleared by reset.
  - Adds output grant_switches[15:0]: counts owner changes between M0 and M1, wrapping.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared constants file: owner encodings (OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2).
- The existing memWidth1/2/4 codes are reused unchanged.
- One sub-module, dm_arb_rr_core, holds owner/last/burst_cnt state and the grant decision.
- The top level does the muxing and response registers.

Test Plan:
- Reset, then M0 load width4 at addr 0x10 holding 0xDEADBEEF: m0_gnt same cycle; next cycle m0_rvalid = 1, m0_rdata = 0xDEADBEEF, m0_exc = 0.
- Both masters request from idle after reset: M0 granted first; M1 granted next cycle, provided M0 deasserts its request.
- Both request continuously, BURST_MAX = 4: grant pattern M0 x4, M1 x4, M0 x4; rvalid pulses follow the grants.
- M1 byte store 0xAB to addr 0x21 while M0 idle: mem_we = 1, mem_width = memWidth1 for one cycle; subsequent M0 lbu at 0x21 returns 0x000000AB.
- M0 load width4 at addr 0x2: m0_exc = 1 with m0_rvalid next cycle.
- Reset asserted during an M1 burst with a store pending: mem_we = 0 that cycle, no rvalid after, owner NONE.
- With DM_ARB_PERFCNT_EN: M1 blocked 3 cycles -> m1_stall_cnt = 3.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: owner encodings,
// memory width codes and the per-master request bundle.
package dm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam logic [1:0] memWidth4 = 2'b00;
    localparam logic [1:0] memWidth2 = 2'b01;
    localparam logic [1:0] memWidth1 = 2'b10;

    typedef struct packed {
        logic        we;
        logic [1:0]  width;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } memReq_t;

    function automatic owner_t otherOf(owner_t o);
        return (o == OWN_M0) ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/dm_arb_rr_core.sv
// Round-robin grant engine with bounded bursts: holds owner/last/burst count
// and decides the same-cycle grant for the two masters.
module dm_arb_rr_core
    import dm_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    owner_t     owner, ownerNext;
    owner_t     last, lastNext;
    owner_t     grantSel;
    logic [3:0] burstCnt, burstNext;
    logic       reqOwn, reqOther;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            last     <= OWN_M1;
            burstCnt <= 4'd0;
        end else begin
            owner    <= ownerNext;
            last     <= lastNext;
            burstCnt <= burstNext;
        end
    end

    always_comb begin
        grantSel  = OWN_NONE;
        ownerNext = OWN_NONE;
        lastNext  = last;
        burstNext = 4'd0;
        reqOwn    = (owner == OWN_M1) ? req1 : req0;
        reqOther  = (owner == OWN_M1) ? req0 : req1;

        // The current owner keeps the port until its burst quota runs out
        // while the other master is waiting.
        if (reset) begin
            grantSel = OWN_NONE;
        end else if (owner != OWN_NONE) begin
            if (reqOwn && (!reqOther || burstCnt < BURST_LIM))
                grantSel = owner;
            else if (reqOther)
                grantSel = otherOf(owner);
        end else if (req0 && req1) begin
            grantSel = otherOf(last);
        end else if (req0) begin
            grantSel = OWN_M0;
        end else if (req1) begin
            grantSel = OWN_M1;
        end

        if (grantSel != OWN_NONE) begin
            ownerNext = grantSel;
            lastNext  = grantSel;
            if (grantSel == owner)
                burstNext = (burstCnt >= BURST_LIM) ? BURST_LIM : burstCnt + 4'd1;
            else
                burstNext = 4'd1;
        end
    end

    always_comb begin
        gnt0 = (grantSel == OWN_M0);
        gnt1 = (grantSel == OWN_M1);
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-master data-memory port arbiter with registered responses.
// Optional stall/switch counters are built when DM_ARB_PERFCNT_EN is defined.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_width,
    input  logic        m0_ext,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_exc,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_width,
    input  logic        m1_ext,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [31:0] m1_pc,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_exc,

    output logic        mem_we,
    output logic [1:0]  mem_width,
    output logic        mem_ext,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata,
    input  logic        mem_exc
`ifdef DM_ARB_PERFCNT_EN
    ,
    output logic [31:0] m0_stall_cnt,
    output logic [31:0] m1_stall_cnt,
    output logic [15:0] grant_switches
`endif
);

    memReq_t req0Bus, req1Bus, selBus;

    dm_arb_rr_core #(.BURST_MAX(BURST_MAX)) u_core (
        .clk   (clk),
        .reset (reset),
        .req0  (m0_req),
        .req1  (m1_req),
        .gnt0  (m0_gnt),
        .gnt1  (m1_gnt)
    );

    assign req0Bus = {m0_we, m0_width, m0_ext, m0_addr, m0_wdata, m0_pc};
    assign req1Bus = {m1_we, m1_width, m1_ext, m1_addr, m1_wdata, m1_pc};

    // Grants are already forced low in reset, so an idle or reset cycle
    // drives an all-zero bus and never writes.
    always_comb begin
        selBus = '0;
        if (m0_gnt)
            selBus = req0Bus;
        else if (m1_gnt)
            selBus = req1Bus;
    end

    assign mem_we    = selBus.we;
    assign mem_width = selBus.width;
    assign mem_ext   = selBus.ext;
    assign mem_addr  = selBus.addr;
    assign mem_wdata = selBus.wdata;
    assign mem_pc    = selBus.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
            m0_exc    <= 1'b0;
            m1_exc    <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (m0_gnt) begin
                m0_rdata <= mem_rdata;
                m0_exc   <= mem_exc;
            end
            if (m1_gnt) begin
                m1_rdata <= mem_rdata;
                m1_exc   <= mem_exc;
            end
        end
    end

`ifdef DM_ARB_PERFCNT_EN
    logic prevGnt0, prevGnt1;

    // A switch is a grant to one master right after a grant to the other.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_stall_cnt   <= 32'd0;
            m1_stall_cnt   <= 32'd0;
            grant_switches <= 16'd0;
            prevGnt0       <= 1'b0;
            prevGnt1       <= 1'b0;
        end else begin
            prevGnt0 <= m0_gnt;
            prevGnt1 <= m1_gnt;
            if (m0_req && !m0_gnt && m0_stall_cnt != 32'hFFFF_FFFF)
                m0_stall_cnt <= m0_stall_cnt + 32'd1;
            if (m1_req && !m1_gnt && m1_stall_cnt != 32'hFFFF_FFFF)
                m1_stall_cnt <= m1_stall_cnt + 32'd1;
            if ((m0_gnt && prevGnt1) || (m1_gnt && prevGnt0))
                grant_switches <= grant_switches + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural arbitration model.
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    localparam int BURST_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_req, m0_we, m0_ext, m1_req, m1_we, m1_ext;
    logic [1:0]  m0_width, m1_width;
    logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc;
    logic        m0_gnt, m0_rvalid, m0_exc, m1_gnt, m1_rvalid, m1_exc;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we, mem_ext, mem_exc;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
`ifdef DM_ARB_PERFCNT_EN
    logic [31:0] m0_stall_cnt, m1_stall_cnt;
    logic [15:0] grant_switches;
`endif

    dm_port_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_width(m0_width), .m0_ext(m0_ext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_exc(m0_exc),
        .m1_req(m1_req), .m1_we(m1_we), .m1_width(m1_width), .m1_ext(m1_ext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_exc(m1_exc),
        .mem_we(mem_we), .mem_width(mem_width), .mem_ext(mem_ext),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_rdata(mem_rdata), .mem_exc(mem_exc)
`ifdef DM_ARB_PERFCNT_EN
        , .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt),
        .grant_switches(grant_switches)
`endif
    );

    // Byte-addressed memory model, 256 bytes, little endian, misaligned
    // accesses flag an exception and are not written.
    logic [7:0] mem [256];
    logic [7:0] rb0, rb1, rb2, rb3;
    assign rb0 = mem[mem_addr[7:0]];
    assign rb1 = mem[mem_addr[7:0] + 8'd1];
    assign rb2 = mem[mem_addr[7:0] + 8'd2];
    assign rb3 = mem[mem_addr[7:0] + 8'd3];

    function automatic logic [31:0] shape(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                          logic [7:0] b3, logic [1:0] w, logic e);
        if (w == memWidth1) return {{24{e & b0[7]}}, b0};
        if (w == memWidth2) return {{16{e & b1[7]}}, b1, b0};
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic misal(logic [31:0] a, logic [1:0] w);
        if (w == memWidth1) return 1'b0;
        if (w == memWidth2) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    assign mem_rdata = shape(rb0, rb1, rb2, rb3, mem_width, mem_ext);
    assign mem_exc   = misal(mem_addr, mem_width);

    always @(posedge clk) begin
        if (mem_we && !mem_exc) begin
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_width != memWidth1) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_width != memWidth1 && mem_width != memWidth2) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic logic [31:0] refRead(logic [31:0] a, logic [1:0] w, logic e);
        return shape(mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3], w, e);
    endfunction

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic setM0(input logic rq, input logic we, input logic [1:0] w, input logic e,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
        m0_req = rq; m0_we = we; m0_width = w; m0_ext = e; m0_addr = a; m0_wdata = d; m0_pc = pc;
    endtask

    task automatic setM1(input logic rq, input logic we, input logic [1:0] w, input logic e,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
        m1_req = rq; m1_we = we; m1_width = w; m1_ext = e; m1_addr = a; m1_wdata = d; m1_pc = pc;
    endtask

    task automatic idleAll();
        setM0(0, 0, 2'b00, 0, 0, 0, 0);
        setM1(0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        idleAll();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Behavioural arbitration model: who held the port last cycle (-1 none),
    // how many grants in a row it has had, and who was granted most recently.
    int hold, streak, lastg;

    function automatic int pick(bit r0, bit r1);
        bit rh, ro;
        if (hold >= 0) begin
            rh = (hold == 0) ? r0 : r1;
            ro = (hold == 0) ? r1 : r0;
            if (rh && (!ro || streak < BURST_MAX)) return hold;
        end
        if (r0 && r1) return (hold >= 0) ? 1 - hold : 1 - lastg;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    typedef struct {
        logic r0, r1;
        logic g0, g1;
    } vec_t;

    vec_t tbl[16];

    logic        pend [2];
    logic        fWe  [2];
    logic [1:0]  fW   [2];
    logic        fE   [2];
    logic [31:0] fA   [2];
    logic [31:0] fD   [2];
    logic [31:0] fPc  [2];
    logic        expV [2];
    logic [31:0] expD [2];
    logic        expE [2];

    initial begin
        logic pg0, pg1;
        int g;

        for (int i = 0; i < 12; i++) begin
            tbl[i].r0 = 1; tbl[i].r1 = 1;
            tbl[i].g0 = (i < 4 || i >= 8);
            tbl[i].g1 = (i >= 4 && i < 8);
        end
        tbl[12] = '{r0: 1, r1: 0, g0: 1, g1: 0};
        tbl[13] = '{r0: 0, r1: 0, g0: 0, g1: 0};
        tbl[14] = '{r0: 1, r1: 1, g0: 0, g1: 1};
        tbl[15] = '{r0: 0, r1: 1, g0: 0, g1: 1};

        reset = 1'b1;
        idleAll();

        // Reset holds grants and writes off even with requests pending.
        @(negedge clk);
        setM0(1, 1, memWidth4, 0, 32'h10, 32'h1111_1111, 32'h100);
        setM1(1, 1, memWidth4, 0, 32'h14, 32'h2222_2222, 32'h200);
        #1;
        check("rst_gnt0", m0_gnt, 0);
        check("rst_gnt1", m1_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        @(negedge clk); #1;
        check("rst_rvalid0", m0_rvalid, 0);
        check("rst_rvalid1", m1_rvalid, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_exc1", m1_exc, 0);
        @(negedge clk);
        reset = 1'b0;
        idleAll();

        // M1 word store then M0 word load of the same location.
        @(negedge clk);
        setM1(1, 1, memWidth4, 0, 32'h10, 32'hDEAD_BEEF, 32'h300);
        #1;
        check("st_gnt1", m1_gnt, 1);
        check("st_mem_we", mem_we, 1);
        @(negedge clk);
        idleAll();
        setM0(1, 0, memWidth4, 0, 32'h10, 0, 32'h400);
        #1;
        check("ld_gnt0", m0_gnt, 1);
        check("ld_mem_we", mem_we, 0);
        check("st_rvalid1", m1_rvalid, 1);
        check("st_exc1", m1_exc, 0);
        @(negedge clk);
        idleAll();
        #1;
        check("ld_rvalid0", m0_rvalid, 1);
        check("ld_rdata0", m0_rdata, 32'hDEAD_BEEF);
        check("ld_exc0", m0_exc, 0);
        check("ld_rvalid1_off", m1_rvalid, 0);

        // Both request out of idle right after reset: M0 first.
        doReset();
        @(negedge clk);
        setM0(1, 0, memWidth4, 0, 32'h10, 0, 0);
        setM1(1, 0, memWidth4, 0, 32'h10, 0, 0);
        #1;
        check("tie_gnt0", m0_gnt, 1);
        check("tie_gnt1", m1_gnt, 0);
        @(negedge clk);
        setM0(0, 0, memWidth4, 0, 0, 0, 0);
        #1;
        check("tie2_gnt1", m1_gnt, 1);
        check("tie2_rvalid0", m0_rvalid, 1);
        @(negedge clk);
        idleAll();
        #1;
        check("tie3_rvalid1", m1_rvalid, 1);
        check("tie3_rdata1", m1_rdata, 32'hDEAD_BEEF);
        check("tie3_rvalid0", m0_rvalid, 0);

        // Byte store by M1, then zero- and sign-extended byte loads by M0.
        @(negedge clk);
        setM1(1, 1, memWidth1, 0, 32'h21, 32'h1234_56AB, 32'h500);
        #1;
        check("sb_gnt1", m1_gnt, 1);
        check("sb_mem_we", mem_we, 1);
        check("sb_mem_width", mem_width, memWidth1);
        check("sb_mem_addr", mem_addr, 32'h21);
        @(negedge clk);
        idleAll();
        setM0(1, 0, memWidth1, 0, 32'h21, 0, 32'h600);
        #1;
        check("lbu_gnt0", m0_gnt, 1);
        check("lbu_mem_we", mem_we, 0);
        @(negedge clk);
        setM0(1, 0, memWidth1, 1, 32'h21, 0, 32'h604);
        #1;
        check("lbu_rdata0", m0_rdata, 32'h0000_00AB);
        check("lbu_rvalid0", m0_rvalid, 1);
        @(negedge clk);
        idleAll();
        #1;
        check("lb_rdata0", m0_rdata, 32'hFFFF_FFAB);

        // Misaligned word load reports an exception with its response.
        @(negedge clk);
        setM0(1, 0, memWidth4, 0, 32'h2, 0, 32'h700);
        #1;
        check("mis_gnt0", m0_gnt, 1);
        @(negedge clk);
        idleAll();
        #1;
        check("mis_rvalid0", m0_rvalid, 1);
        check("mis_exc0", m0_exc, 1);

        // Reset mid-way through an M1 store burst.
        @(negedge clk);
        setM1(1, 1, memWidth4, 0, 32'h40, 32'hCAFE_F00D, 32'h800);
        #1;
        check("bst_gnt1a", m1_gnt, 1);
        @(negedge clk); #1;
        check("bst_gnt1b", m1_gnt, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("bst_rst_mem_we", mem_we, 0);
        check("bst_rst_gnt1", m1_gnt, 0);
        @(negedge clk);
        reset = 1'b0;
        setM0(1, 0, memWidth4, 0, 32'h10, 0, 0);
        #1;
        check("bst_after_rvalid1", m1_rvalid, 0);
        check("bst_after_gnt0", m0_gnt, 1);
        check("bst_after_gnt1", m1_gnt, 0);

        // Vector table: contention pattern with BURST_MAX = 4.
        doReset();
        setM0(0, 0, memWidth4, 0, 32'h10, 0, 32'h900);
        setM1(0, 0, memWidth4, 0, 32'h14, 0, 32'hA00);
        pg0 = 0; pg1 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            m0_req = tbl[i].r0;
            m1_req = tbl[i].r1;
            #1;
            check($sformatf("tbl%0d_gnt0", i), m0_gnt, tbl[i].g0);
            check($sformatf("tbl%0d_gnt1", i), m1_gnt, tbl[i].g1);
            check($sformatf("tbl%0d_rvalid0", i), m0_rvalid, pg0);
            check($sformatf("tbl%0d_rvalid1", i), m1_rvalid, pg1);
            pg0 = tbl[i].g0;
            pg1 = tbl[i].g1;
        end

        // Randomized traffic against the behavioural model.
        doReset();
        hold = -1; streak = 0; lastg = 1;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; fWe[m] = 0; fW[m] = 0; fE[m] = 0; fA[m] = 0; fD[m] = 0; fPc[m] = 0;
            expV[m] = 0; expD[m] = 0; expE[m] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 9) < 6) begin
                    pend[m] = 1;
                    fWe[m] = 1'($urandom_range(0, 1));
                    fW[m]  = 2'($urandom_range(0, 2));
                    fE[m]  = 1'($urandom_range(0, 1));
                    fA[m]  = $urandom;
                    fD[m]  = $urandom;
                    fPc[m] = $urandom;
                end
            end
            setM0(pend[0], fWe[0], fW[0], fE[0], fA[0], fD[0], fPc[0]);
            setM1(pend[1], fWe[1], fW[1], fE[1], fA[1], fD[1], fPc[1]);
            #1;
            g = reset ? -1 : pick(pend[0], pend[1]);
            check("rnd_gnt0", m0_gnt, g == 0);
            check("rnd_gnt1", m1_gnt, g == 1);
            check("rnd_mem_we", mem_we, (g >= 0) ? fWe[g] : 1'b0);
            check("rnd_mem_width", mem_width, (g >= 0) ? fW[g] : 2'b00);
            check("rnd_mem_ext", mem_ext, (g >= 0) ? fE[g] : 1'b0);
            check("rnd_mem_addr", mem_addr, (g >= 0) ? fA[g] : 32'd0);
            check("rnd_mem_wdata", mem_wdata, (g >= 0) ? fD[g] : 32'd0);
            check("rnd_mem_pc", mem_pc, (g >= 0) ? fPc[g] : 32'd0);
            check("rnd_rvalid0", m0_rvalid, expV[0]);
            check("rnd_rvalid1", m1_rvalid, expV[1]);
            check("rnd_rdata0", m0_rdata, expD[0]);
            check("rnd_rdata1", m1_rdata, expD[1]);
            check("rnd_exc0", m0_exc, expE[0]);
            check("rnd_exc1", m1_exc, expE[1]);
            if (reset) begin
                expV[0] = 0; expV[1] = 0; expD[0] = 0; expD[1] = 0; expE[0] = 0; expE[1] = 0;
                hold = -1; streak = 0; lastg = 1;
            end else begin
                expV[0] = (g == 0);
                expV[1] = (g == 1);
                if (g >= 0) begin
                    expD[g] = refRead(fA[g], fW[g], fE[g]);
                    expE[g] = misal(fA[g], fW[g]);
                    streak = (g == hold) ? streak + 1 : 1;
                    hold = g;
                    lastg = g;
                    pend[g] = 0;
                end else begin
                    hold = -1;
                    streak = 0;
                end
            end
        end
        reset = 1'b0;

`ifdef DM_ARB_PERFCNT_EN
        // M1 waits out three more M0 grants before it gets the port.
        doReset();
        @(negedge clk);
        setM0(1, 0, memWidth4, 0, 32'h10, 0, 0);
        @(negedge clk);
        setM1(1, 0, memWidth4, 0, 32'h14, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("pc_gnt1", m1_gnt, 1);
        @(negedge clk);
        idleAll();
        #1;
        check("pc_m1_stall", m1_stall_cnt, 3);
        check("pc_switches", grant_switches, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
